// File: rtl/barrel_shift_left_pipe.sv
// Five-stage logical left barrel shifter with valid/ready on both sides.
// Each stage applies one power-of-two shift; the whole pipe freezes when the output is stalled.
module barrel_shift_left_pipe #(
  parameter int DATA_W = 64,
  parameter int SAMT_W = 5,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SAMT_W-1:0] in_samt,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int N_STG = SAMT_W;

  logic              stall;

  logic              stg_valid [N_STG];
  logic [DATA_W-1:0] stg_data  [N_STG];
  logic [SAMT_W-1:0] stg_samt  [N_STG];
  logic [TAG_W-1:0]  stg_tag   [N_STG];

  logic              up_valid  [N_STG];
  logic [DATA_W-1:0] up_data   [N_STG];
  logic [SAMT_W-1:0] up_samt   [N_STG];
  logic [TAG_W-1:0]  up_tag    [N_STG];

  logic [DATA_W-1:0] nxt_data  [N_STG];
  logic [SAMT_W-1:0] nxt_samt  [N_STG];

  // Bubbles are not squeezed out: a stalled output freezes every stage.
  assign stall    = stg_valid[N_STG-1] & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    up_valid[0] = in_valid & in_ready;
    up_data[0]  = in_data;
    up_samt[0]  = in_samt;
    up_tag[0]   = in_tag;
    for (int s = 1; s < N_STG; s++) begin
      up_valid[s] = stg_valid[s-1];
      up_data[s]  = stg_data[s-1];
      up_samt[s]  = stg_samt[s-1];
      up_tag[s]   = stg_tag[s-1];
    end
  end

  // Stage s consumes samt bit (SAMT_W-1-s), i.e. shifts by 16, 8, 4, 2, 1 in order.
  always_comb begin
    for (int s = 0; s < N_STG; s++) begin
      nxt_data[s] = up_samt[s][SAMT_W-1-s] ? (up_data[s] << (1 << (SAMT_W-1-s))) : up_data[s];
      nxt_samt[s] = up_samt[s];
      nxt_samt[s][SAMT_W-1-s] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < N_STG; s++) begin
        stg_valid[s] <= 1'b0;
        stg_data[s]  <= '0;
        stg_samt[s]  <= '0;
        stg_tag[s]   <= '0;
      end
    end else if (!stall) begin
      for (int s = 0; s < N_STG; s++) begin
        stg_valid[s] <= up_valid[s];
        if (up_valid[s]) begin
          stg_data[s] <= nxt_data[s];
          stg_samt[s] <= nxt_samt[s];
          stg_tag[s]  <= up_tag[s];
        end
      end
    end
  end

  assign out_valid = stg_valid[N_STG-1];
  assign out_data  = stg_data[N_STG-1];
  assign out_tag   = stg_tag[N_STG-1];

endmodule
